// File: rtl/imem_pkg.sv
// -----------------------------------------------------------------------------
// imem_pkg
// Shared types and constants for the instruction-memory responder.
//   NOP_INSTR    : word returned on an erroneous fetch (addi x0,x0,0)
//   imem_state_t : grant FSM states
//   imem_rsp_t   : one response slot travelling down the latency pipe
// -----------------------------------------------------------------------------
package imem_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    READY = 2'd2
  } imem_state_t;

  typedef struct packed {
    logic        valid;
    logic        err;
    logic [31:0] data;
  } imem_rsp_t;

endpackage

// File: rtl/instr_mem_rsp_pipe.sv
// -----------------------------------------------------------------------------
// instr_mem_rsp_pipe
// Fixed-latency response delay line. A response entering on rsp_i appears on
// rsp_o exactly RSP_LAT rising edges later. Payload fields only move along
// with a valid entry, so the output payload holds its last valid value.
// Ports:
//   clk_i  : clock
//   rst_i  : asynchronous active-high reset, drops every in-flight response
//   rsp_i  : response captured on this edge (valid marks a grant)
//   rsp_o  : registered delayed response
// -----------------------------------------------------------------------------
module instr_mem_rsp_pipe
  import imem_pkg::*;
#(
  parameter int RSP_LAT = 1
) (
  input  logic      clk_i,
  input  logic      rst_i,
  input  imem_rsp_t rsp_i,
  output imem_rsp_t rsp_o
);

  imem_rsp_t stage_q [RSP_LAT];

  // Shift register; valid always advances, payload advances only with valid
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < RSP_LAT; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0].valid <= rsp_i.valid;
      if (rsp_i.valid) begin
        stage_q[0].err  <= rsp_i.err;
        stage_q[0].data <= rsp_i.data;
      end
      for (int i = 1; i < RSP_LAT; i++) begin
        stage_q[i].valid <= stage_q[i-1].valid;
        if (stage_q[i-1].valid) begin
          stage_q[i].err  <= stage_q[i-1].err;
          stage_q[i].data <= stage_q[i-1].data;
        end
      end
    end
  end

  assign rsp_o = stage_q[RSP_LAT-1];

endmodule

// File: rtl/instr_mem_responder.sv
// -----------------------------------------------------------------------------
// instr_mem_responder
// Memory-side model of the instruction bus: grants fetch requests after
// GNT_WAIT wait states and returns the addressed word RSP_LAT cycles after
// the grant edge. The word store is preloaded through a side load port and is
// never cleared by reset.
// Ports:
//   req              : clock (all state changes on its rising edge)
//   reset            : asynchronous active-high reset
//   instr_req_in     : fetch request
//   instr_addr_in    : byte address, sampled on the grant edge
//   gnt_out          : grant (accepted when instr_req_in && gnt_out)
//   instr_rvalid_out : one-cycle response strobe
//   instr_rdata_out  : instruction word, holds while rvalid is low
//   instr_err_out    : response error, qualified by rvalid
//   load_we_in       : store write enable (ignored during reset)
//   load_addr_in     : word index to write
//   load_data_in     : word to write
// -----------------------------------------------------------------------------
module instr_mem_responder
  import imem_pkg::*;
#(
  parameter int          DEPTH     = 256,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          GNT_WAIT  = 0,
  parameter int          RSP_LAT   = 1
) (
  input  logic                     req,
  input  logic                     reset,
  input  logic                     instr_req_in,
  input  logic [31:0]              instr_addr_in,
  output logic                     gnt_out,
  output logic                     instr_rvalid_out,
  output logic [31:0]              instr_rdata_out,
  output logic                     instr_err_out,
  input  logic                     load_we_in,
  input  logic [$clog2(DEPTH)-1:0] load_addr_in,
  input  logic [31:0]              load_data_in
);

  localparam int          AW        = $clog2(DEPTH);
  localparam logic [31:0] DEPTH_W   = 32'(DEPTH);
  localparam logic [3:0]  WAIT_LOAD = 4'(GNT_WAIT - 1);

  imem_state_t state_q, state_d;
  logic [3:0]  wait_cnt_q, wait_cnt_d;
  logic        gnt_s;
  logic        grant_s;
  logic [31:0] offset_s;
  logic [31:0] word_idx_s;
  logic        addr_err_s;
  imem_rsp_t   rsp_in_s;
  imem_rsp_t   rsp_out_s;

  logic [31:0] mem [DEPTH];

  // Grant FSM state and wait counter
  always_ff @(posedge req or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      wait_cnt_q <= 4'd0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Next-state and raw grant. WAIT covers GNT_WAIT-1 cycles (IDLE is the
  // first held cycle), so READY and thus the grant land on held cycle
  // GNT_WAIT+1. With GNT_WAIT==1 there is no WAIT cycle at all.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    gnt_s      = 1'b0;
    case (state_q)
      IDLE: begin
        if (GNT_WAIT == 0) begin
          gnt_s = instr_req_in;
        end else if (instr_req_in) begin
          if (GNT_WAIT == 1) begin
            state_d = READY;
          end else begin
            state_d    = WAIT;
            wait_cnt_d = WAIT_LOAD;
          end
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (!instr_req_in) begin
          state_d    = IDLE;
          wait_cnt_d = 4'd0;
        end else if (wait_cnt_q <= 4'd1) begin
          state_d    = READY;
          wait_cnt_d = 4'd0;
        end else begin
          wait_cnt_d = wait_cnt_q - 4'd1;
        end
      end
      READY: begin
        // Either granted or dropped: both return to IDLE, so a held
        // request is re-arbitrated as a new one.
        gnt_s   = instr_req_in;
        state_d = IDLE;
      end
      default: begin
        state_d    = IDLE;
        wait_cnt_d = 4'd0;
      end
    endcase
  end

  // Grant is held low through reset even in the zero-wait configuration
  assign gnt_out = gnt_s & ~reset;
  assign grant_s = gnt_out & instr_req_in;

  // Address decode and store read for the response captured on the grant edge
  always_comb begin
    offset_s       = instr_addr_in - BASE_ADDR;
    word_idx_s     = offset_s >> 5'd2;
    addr_err_s     = (instr_addr_in[1:0] != 2'b00) ||
                     (word_idx_s >= DEPTH_W) ||
                     (instr_addr_in < BASE_ADDR);
    rsp_in_s.valid = grant_s;
    rsp_in_s.err   = addr_err_s;
    if (addr_err_s) begin
      rsp_in_s.data = NOP_INSTR;
    end else begin
      rsp_in_s.data = mem[word_idx_s[AW-1:0]];
    end
  end

  // Load port write; the read above sees the pre-edge word (read-before-write)
  always_ff @(posedge req) begin
    if (load_we_in && !reset) begin
      mem[load_addr_in] <= load_data_in;
    end
  end

  instr_mem_rsp_pipe #(
    .RSP_LAT (RSP_LAT)
  ) u_rsp_pipe (
    .clk_i (req),
    .rst_i (reset),
    .rsp_i (rsp_in_s),
    .rsp_o (rsp_out_s)
  );

  assign instr_rvalid_out = rsp_out_s.valid;
  assign instr_err_out    = rsp_out_s.err;
  assign instr_rdata_out  = rsp_out_s.data;

endmodule

// File: tb/tb_instr_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_instr_mem_responder
// Directed bench for instr_mem_responder. Four instances share clock, reset,
// request and load inputs; each phase resets them all and checks the instance
// whose configuration the phase targets:
//   u_dut_a  : defaults (GNT_WAIT=0, RSP_LAT=1)
//   u_dut_w3 : GNT_WAIT=3
//   u_dut_w2 : GNT_WAIT=2
//   u_dut_l3 : RSP_LAT=3
// Inputs are driven 1 time unit after the rising edge, outputs sampled 1 unit
// later.
// -----------------------------------------------------------------------------
module tb_instr_mem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        instr_req;
  logic [31:0] instr_addr;
  logic        load_we;
  logic [7:0]  load_addr;
  logic [31:0] load_data;

  logic        gnt_a, rvalid_a, err_a;
  logic [31:0] rdata_a;
  logic        gnt_w3, rvalid_w3, err_w3;
  logic [31:0] rdata_w3;
  logic        gnt_w2, rvalid_w2, err_w2;
  logic [31:0] rdata_w2;
  logic        gnt_l3, rvalid_l3, err_l3;
  logic [31:0] rdata_l3;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  instr_mem_responder u_dut_a (
    .req (clk), .reset (reset), .instr_req_in (instr_req), .instr_addr_in (instr_addr),
    .gnt_out (gnt_a), .instr_rvalid_out (rvalid_a), .instr_rdata_out (rdata_a),
    .instr_err_out (err_a), .load_we_in (load_we), .load_addr_in (load_addr),
    .load_data_in (load_data)
  );

  instr_mem_responder #(.GNT_WAIT (3)) u_dut_w3 (
    .req (clk), .reset (reset), .instr_req_in (instr_req), .instr_addr_in (instr_addr),
    .gnt_out (gnt_w3), .instr_rvalid_out (rvalid_w3), .instr_rdata_out (rdata_w3),
    .instr_err_out (err_w3), .load_we_in (load_we), .load_addr_in (load_addr),
    .load_data_in (load_data)
  );

  instr_mem_responder #(.GNT_WAIT (2)) u_dut_w2 (
    .req (clk), .reset (reset), .instr_req_in (instr_req), .instr_addr_in (instr_addr),
    .gnt_out (gnt_w2), .instr_rvalid_out (rvalid_w2), .instr_rdata_out (rdata_w2),
    .instr_err_out (err_w2), .load_we_in (load_we), .load_addr_in (load_addr),
    .load_data_in (load_data)
  );

  instr_mem_responder #(.RSP_LAT (3)) u_dut_l3 (
    .req (clk), .reset (reset), .instr_req_in (instr_req), .instr_addr_in (instr_addr),
    .gnt_out (gnt_l3), .instr_rvalid_out (rvalid_l3), .instr_rdata_out (rdata_l3),
    .instr_err_out (err_l3), .load_we_in (load_we), .load_addr_in (load_addr),
    .load_data_in (load_data)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input logic [7:0] a, input logic [31:0] d);
    load_we   = 1'b1;
    load_addr = a;
    load_data = d;
    next_cycle();
    load_we   = 1'b0;
  endtask

  // Reset pulse; also attempts a store write that must be ignored
  task automatic do_reset();
    reset     = 1'b1;
    instr_req = 1'b0;
    load_we   = 1'b1;
    load_addr = 8'd5;
    load_data = 32'h2222_2222;
    next_cycle();
    next_cycle();
    reset   = 1'b0;
    load_we = 1'b0;
    next_cycle();
  endtask

  initial begin
    reset      = 1'b1;
    instr_req  = 1'b0;
    instr_addr = 32'd0;
    load_we    = 1'b0;
    load_addr  = 8'd0;
    load_data  = 32'd0;

    // Reset state, grant forced low with a request present
    next_cycle();
    instr_req = 1'b1;
    #1;
    check_val("rst_gnt_a", {31'd0, gnt_a}, 32'd0);
    check_val("rst_gnt_l3", {31'd0, gnt_l3}, 32'd0);
    check_val("rst_rvalid_a", {31'd0, rvalid_a}, 32'd0);
    check_val("rst_rdata_a", rdata_a, 32'd0);
    check_val("rst_err_a", {31'd0, err_a}, 32'd0);
    next_cycle();
    instr_req = 1'b0;
    reset     = 1'b0;
    next_cycle();

    load_word(8'd0, 32'h0010_8093);
    load_word(8'd1, 32'h0031_8193);
    load_word(8'd2, 32'h00A0_0513);
    load_word(8'd5, 32'h1111_1111);
    next_cycle();

    // Defaults: back-to-back fetches of words 0 and 1
    instr_req  = 1'b1;
    instr_addr = 32'd0;
    #1;
    check_val("t1_gnt0", {31'd0, gnt_a}, 32'd1);
    next_cycle();
    check_val("t1_rvalid0", {31'd0, rvalid_a}, 32'd1);
    check_val("t1_rdata0", rdata_a, 32'h0010_8093);
    check_val("t1_err0", {31'd0, err_a}, 32'd0);
    instr_addr = 32'd4;
    #1;
    check_val("t1_gnt1", {31'd0, gnt_a}, 32'd1);
    next_cycle();
    check_val("t1_rvalid1", {31'd0, rvalid_a}, 32'd1);
    check_val("t1_rdata1", rdata_a, 32'h0031_8193);
    instr_req = 1'b0;
    next_cycle();
    check_val("t1_rvalid_end", {31'd0, rvalid_a}, 32'd0);
    check_val("t1_rdata_hold", rdata_a, 32'h0031_8193);

    // GNT_WAIT=3: grant on held cycles 4 and 8, response one cycle later
    do_reset();
    instr_req  = 1'b1;
    instr_addr = 32'd8;
    for (int cyc = 1; cyc <= 8; cyc++) begin
      #1;
      check_val($sformatf("t2_gnt_c%0d", cyc), {31'd0, gnt_w3}, {31'd0, (cyc == 4 || cyc == 8)});
      check_val($sformatf("t2_rvalid_c%0d", cyc), {31'd0, rvalid_w3}, {31'd0, (cyc == 5)});
      if (cyc == 5) begin
        check_val("t2_rdata", rdata_w3, 32'h00A0_0513);
        check_val("t2_err", {31'd0, err_w3}, 32'd0);
      end
      next_cycle();
    end
    check_val("t2_rvalid_c9", {31'd0, rvalid_w3}, 32'd1);
    instr_req = 1'b0;
    next_cycle();

    // GNT_WAIT=2: request dropped in WAIT, then a fresh request restarts
    do_reset();
    instr_req  = 1'b1;
    instr_addr = 32'd0;
    #1;
    check_val("t3_gnt_c1", {31'd0, gnt_w2}, 32'd0);
    next_cycle();
    instr_req = 1'b0;
    #1;
    check_val("t3_gnt_c2", {31'd0, gnt_w2}, 32'd0);
    next_cycle();
    check_val("t3_rvalid_c3", {31'd0, rvalid_w2}, 32'd0);
    next_cycle();
    check_val("t3_rvalid_c4", {31'd0, rvalid_w2}, 32'd0);
    instr_req = 1'b1;
    #1;
    check_val("t3_regnt_c4", {31'd0, gnt_w2}, 32'd0);
    next_cycle();
    check_val("t3_regnt_c5", {31'd0, gnt_w2}, 32'd0);
    check_val("t3_rvalid_c5", {31'd0, rvalid_w2}, 32'd0);
    next_cycle();
    check_val("t3_regnt_c6", {31'd0, gnt_w2}, 32'd1);
    instr_req = 1'b0;
    next_cycle();

    // Error responses, then a word whose reset-time overwrite was ignored
    do_reset();
    instr_req  = 1'b1;
    instr_addr = 32'h0000_0002;
    #1;
    check_val("t4_gnt", {31'd0, gnt_a}, 32'd1);
    next_cycle();
    check_val("t4_mis_rvalid", {31'd0, rvalid_a}, 32'd1);
    check_val("t4_mis_err", {31'd0, err_a}, 32'd1);
    check_val("t4_mis_rdata", rdata_a, 32'h0000_0013);
    instr_addr = 32'h0000_0400;
    next_cycle();
    check_val("t4_oob_rvalid", {31'd0, rvalid_a}, 32'd1);
    check_val("t4_oob_err", {31'd0, err_a}, 32'd1);
    check_val("t4_oob_rdata", rdata_a, 32'h0000_0013);
    instr_addr = 32'd20;
    next_cycle();
    check_val("t4_w5_err", {31'd0, err_a}, 32'd0);
    check_val("t4_w5_rdata", rdata_a, 32'h1111_1111);
    instr_req = 1'b0;
    next_cycle();

    // RSP_LAT=3: three grants, reset lands while two are still in flight
    do_reset();
    instr_req  = 1'b1;
    instr_addr = 32'd0;
    #1;
    check_val("t5_gnt_c1", {31'd0, gnt_l3}, 32'd1);
    next_cycle();
    check_val("t5_rvalid_c2", {31'd0, rvalid_l3}, 32'd0);
    instr_addr = 32'd4;
    next_cycle();
    check_val("t5_rvalid_c3", {31'd0, rvalid_l3}, 32'd0);
    instr_addr = 32'd8;
    #1;
    check_val("t5_gnt_c3", {31'd0, gnt_l3}, 32'd1);
    next_cycle();
    check_val("t5_rvalid_c4", {31'd0, rvalid_l3}, 32'd1);
    check_val("t5_rdata_c4", rdata_l3, 32'h0010_8093);
    instr_req = 1'b0;
    next_cycle();
    reset     = 1'b1;
    instr_req = 1'b1;
    #1;
    check_val("t5_rst_rvalid", {31'd0, rvalid_l3}, 32'd0);
    check_val("t5_rst_rdata", rdata_l3, 32'd0);
    check_val("t5_rst_err", {31'd0, err_l3}, 32'd0);
    check_val("t5_rst_gnt", {31'd0, gnt_l3}, 32'd0);
    next_cycle();
    check_val("t5_rst_rvalid2", {31'd0, rvalid_l3}, 32'd0);
    next_cycle();
    reset     = 1'b0;
    instr_req = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      check_val($sformatf("t5_post_rvalid%0d", k), {31'd0, rvalid_l3}, 32'd0);
      next_cycle();
    end

    // Same-edge load write and fetch of word 2: old word, then new word
    do_reset();
    instr_req  = 1'b1;
    instr_addr = 32'd8;
    load_we    = 1'b1;
    load_addr  = 8'd2;
    load_data  = 32'hDEAD_BEEF;
    #1;
    check_val("t6_gnt", {31'd0, gnt_a}, 32'd1);
    next_cycle();
    load_we = 1'b0;
    check_val("t6_old_rvalid", {31'd0, rvalid_a}, 32'd1);
    check_val("t6_old_rdata", rdata_a, 32'h00A0_0513);
    next_cycle();
    check_val("t6_new_rvalid", {31'd0, rvalid_a}, 32'd1);
    check_val("t6_new_rdata", rdata_a, 32'hDEAD_BEEF);
    instr_req = 1'b0;
    next_cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
